// File: rtl/vending_coin_arbiter_if.sv
// Coin-arbiter bundle: slot handshakes, vending-machine coin/result link, status.
// COIN_ARB_STATS_EN adds the vend/coin statistics counters.
interface vending_coin_arbiter_if #(
  parameter int NUM_SLOTS = 2
);
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic [NUM_SLOTS-1:0]   slot_req_i;
  logic [2*NUM_SLOTS-1:0] slot_coin_i;
  logic [NUM_SLOTS-1:0]   slot_ack_o;
  logic                   nickel_o;
  logic                   dime_o;
  logic                   quarter_o;
  logic                   vm_soda_i;
  logic [2:0]             vm_change_i;
  logic                   vend_valid_o;
  logic [SLOT_W-1:0]      vend_slot_o;
  logic [2:0]             vend_change_o;
  logic                   reject_o;
  logic [2:0]             credit_o;
  logic                   busy_o;
  logic                   err_o;
`ifdef COIN_ARB_STATS_EN
  logic [15:0]            vend_cnt_o;
  logic [15:0]            coin_cnt_o;
`endif

  modport slave (
`ifdef COIN_ARB_STATS_EN
    output vend_cnt_o, coin_cnt_o,
`endif
    input  slot_req_i, slot_coin_i, vm_soda_i, vm_change_i,
    output slot_ack_o, nickel_o, dime_o, quarter_o, vend_valid_o, vend_slot_o,
    output vend_change_o, reject_o, credit_o, busy_o, err_o
  );

  modport master (
`ifdef COIN_ARB_STATS_EN
    input  vend_cnt_o, coin_cnt_o,
`endif
    output slot_req_i, slot_coin_i, vm_soda_i, vm_change_i,
    input  slot_ack_o, nickel_o, dime_o, quarter_o, vend_valid_o, vend_slot_o,
    input  vend_change_o, reject_o, credit_o, busy_o, err_o
  );
endinterface

// File: rtl/vending_coin_arbiter.sv
// Round-robin arbiter sharing one vending-machine coin port among NUM_SLOTS slots,
// mirroring machine credit. COIN_ARB_STATS_EN adds vend/coin counters.
//
// state | meaning
// IDLE  | arbitrate; invalid codes acked+rejected here
// ISSUE | ack winner, drive one coin pulse
// WAIT  | VM_LAT cycles until machine result, then sample
module vending_coin_arbiter #(
  parameter int NUM_SLOTS = 2,
  parameter int VM_LAT    = 1,
  parameter int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  vending_coin_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] ptr_q, win, win_q;
  logic [1:0]        win_code, code_q;
  logic              any_req;
  logic [1:0]        wait_q;
  logic              sample;
  logic [3:0]        coin_val, new_credit;
  logic [2:0]        exp_change, credit_q;
  logic              exp_soda, miss;

  always_comb begin
    any_req  = 1'b0;
    win      = '0;
    win_code = 2'b00;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      int idx;
      idx = (int'(ptr_q) + i) % NUM_SLOTS;
      if (!any_req && bus.slot_req_i[idx]) begin
        any_req  = 1'b1;
        win      = SLOT_W'(idx);
        win_code = bus.slot_coin_i[2*idx +: 2];
      end
    end
  end

  function automatic logic [SLOT_W-1:0] next_ptr(input logic [SLOT_W-1:0] w);
    return (int'(w) == NUM_SLOTS - 1) ? '0 : w + 1'b1;
  endfunction

  assign sample = (state_q == WAIT) && (wait_q == 2'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req && win_code != 2'b00) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (sample) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.slot_ack_o = '0;
    bus.reject_o   = 1'b0;
    bus.nickel_o   = 1'b0;
    bus.dime_o     = 1'b0;
    bus.quarter_o  = 1'b0;
    bus.busy_o     = (state_q != IDLE);
    case (state_q)
      IDLE: if (any_req && win_code == 2'b00) begin
        bus.slot_ack_o[win] = 1'b1;
        bus.reject_o        = 1'b1;
      end
      ISSUE: begin
        bus.slot_ack_o[win_q] = 1'b1;
        bus.nickel_o          = (code_q == 2'b01);
        bus.dime_o            = (code_q == 2'b10);
        bus.quarter_o         = (code_q == 2'b11);
      end
      default: ;
    endcase
  end

  always_comb begin
    case (code_q)
      2'b01:   coin_val = 4'd1;
      2'b10:   coin_val = 4'd2;
      2'b11:   coin_val = 4'd5;
      default: coin_val = 4'd0;
    endcase
    new_credit = {1'b0, credit_q} + coin_val;
    exp_soda   = (new_credit >= 4'd4);
    exp_change = 3'(new_credit - 4'd4);
    miss       = exp_soda ? (!bus.vm_soda_i || bus.vm_change_i != exp_change) : bus.vm_soda_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q             <= '0;
      win_q             <= '0;
      code_q            <= 2'b00;
      wait_q            <= 2'd0;
      credit_q          <= 3'd0;
      bus.err_o         <= 1'b0;
      bus.vend_valid_o  <= 1'b0;
      bus.vend_slot_o   <= '0;
      bus.vend_change_o <= 3'd0;
    end else begin
      bus.vend_valid_o <= 1'b0;
      if (state_q == IDLE && any_req) begin
        if (win_code == 2'b00) begin
          ptr_q <= next_ptr(win);
        end else begin
          win_q  <= win;
          code_q <= win_code;
        end
      end
      if (state_q == ISSUE) begin
        ptr_q  <= next_ptr(win_q);
        wait_q <= 2'(VM_LAT - 1);
      end else if (state_q == WAIT && wait_q != 2'd0) begin
        wait_q <= wait_q - 2'd1;
      end
      // On a miss the machine's view wins: it owns the real credit.
      if (sample) begin
        if (miss) bus.err_o <= 1'b1;
        if (bus.vm_soda_i) begin
          bus.vend_valid_o  <= 1'b1;
          bus.vend_slot_o   <= win_q;
          bus.vend_change_o <= bus.vm_change_i;
          credit_q          <= 3'd0;
        end else begin
          credit_q <= (new_credit > 4'd3) ? 3'd3 : new_credit[2:0];
        end
      end
    end
  end

  assign bus.credit_o = credit_q;

`ifdef COIN_ARB_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.vend_cnt_o <= 16'd0;
      bus.coin_cnt_o <= 16'd0;
    end else begin
      if (bus.vend_valid_o && bus.vend_cnt_o != 16'hFFFF) bus.vend_cnt_o <= bus.vend_cnt_o + 16'd1;
      if (state_q == ISSUE && bus.coin_cnt_o != 16'hFFFF) bus.coin_cnt_o <= bus.coin_cnt_o + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_vending_coin_arbiter.sv
// Directed bench for vending_coin_arbiter with a behavioural vending machine
// and a vend scoreboard checked by an independent monitor.
module tb_vending_coin_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [3:0] coin = 4'b0000;
  logic       force_no_soda = 1'b0;
  logic       m_soda;
  logic [2:0] m_change;
  logic [2:0] m_credit;
  int         passed = 0;
  int         total = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  vending_coin_arbiter_if #(.NUM_SLOTS(2)) bus();

  assign bus.slot_req_i  = req;
  assign bus.slot_coin_i = coin;
  assign bus.vm_soda_i   = m_soda;
  assign bus.vm_change_i = m_change;

  vending_coin_arbiter #(.NUM_SLOTS(2), .VM_LAT(1)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  // vending machine: 20c soda, result registered one cycle after the coin
  always @(posedge clk or negedge rst_n) begin
    int v, n;
    if (!rst_n) begin
      m_credit <= 3'd0;
      m_soda   <= 1'b0;
      m_change <= 3'd0;
    end else begin
      v = bus.nickel_o ? 1 : bus.dime_o ? 2 : bus.quarter_o ? 5 : 0;
      n = int'(m_credit) + v;
      m_soda   <= 1'b0;
      m_change <= 3'd0;
      if (v != 0) begin
        if (n >= 4) begin
          m_soda   <= !force_no_soda;
          m_change <= 3'(n - 4);
          m_credit <= 3'd0;
        end else begin
          m_credit <= 3'(n);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // monitor: every vend pulse must match the oldest expected {slot, change}
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.vend_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_vend", {bus.vend_slot_o, bus.vend_change_o}, 32'hEE);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          check("vend_slot_change", {bus.vend_slot_o, bus.vend_change_o}, e);
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      #1;
      if (!bus.busy_o) break;
    end
    check("idle_timeout", 32'(n < 20), 1);
  endtask

  task automatic send_coin(input int s, input logic [1:0] code, input logic [2:0] exp_credit);
    logic [2:0] exp_coins;
    bit got;
    got = 0;
    exp_coins = (code == 2'b01) ? 3'b100 : (code == 2'b10) ? 3'b010 : 3'b001;
    @(negedge clk);
    req[s] = 1'b1;
    coin[2*s +: 2] = code;
    for (int n = 0; n < 20 && !got; n++) begin
      #1;
      if (bus.slot_ack_o[s]) got = 1;
      else @(negedge clk);
    end
    check("ack_seen", 32'(got), 1);
    check("ack_onehot", 32'(bus.slot_ack_o), 32'(2'b01 << s));
    check("coin_pulse", {bus.nickel_o, bus.dime_o, bus.quarter_o}, exp_coins);
    req[s] = 1'b0;
    coin[2*s +: 2] = 2'b00;
    wait_idle();
    check("credit", bus.credit_o, exp_credit);
  endtask

  initial begin
    int t0, t1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", {bus.slot_ack_o, bus.nickel_o, bus.dime_o, bus.quarter_o,
          bus.vend_valid_o, bus.reject_o, bus.credit_o, bus.busy_o, bus.err_o}, 0);
    rst_n = 1'b1;

    // four nickels from slot0
    exp_q.push_back({1'b0, 3'd0});
    send_coin(0, 2'b01, 3'd1);
    send_coin(0, 2'b01, 3'd2);
    send_coin(0, 2'b01, 3'd3);
    send_coin(0, 2'b01, 3'd0);

    // slot1: three nickels then a dime -> 5 nickels, change 1
    exp_q.push_back({1'b1, 3'd1});
    send_coin(1, 2'b01, 3'd1);
    send_coin(1, 2'b01, 3'd2);
    send_coin(1, 2'b01, 3'd3);
    send_coin(1, 2'b10, 3'd0);

    // both slots insert a quarter together
    exp_q.push_back({1'b0, 3'd1});
    exp_q.push_back({1'b1, 3'd1});
    t0 = -1;
    t1 = -1;
    @(negedge clk);
    req  = 2'b11;
    coin = 4'b1111;
    for (int n = 0; n < 30 && req != 2'b00; n++) begin
      #1;
      if (bus.slot_ack_o[0] && t0 < 0) begin t0 = n; req[0] = 1'b0; end
      if (bus.slot_ack_o[1] && t1 < 0) begin t1 = n; req[1] = 1'b0; end
      @(negedge clk);
    end
    coin = 4'b0000;
    check("rr_slot0_acked", 32'(t0 >= 0), 1);
    check("rr_slot1_after_3", t1, t0 + 3);
    wait_idle();
    check("rr_credit", bus.credit_o, 0);

    // invalid code: ack and reject together, no coin
    @(negedge clk);
    req[0] = 1'b1;
    #1;
    check("reject_ack", {bus.slot_ack_o, bus.reject_o}, 3'b011);
    check("reject_no_coin", {bus.nickel_o, bus.dime_o, bus.quarter_o, bus.busy_o}, 0);
    req[0] = 1'b0;
    @(negedge clk);
    #1;
    check("reject_pulse_len", bus.reject_o, 0);
    check("reject_credit", bus.credit_o, 0);

    // reset in WAIT after a dime
    @(negedge clk);
    req[0]  = 1'b1;
    coin[1:0] = 2'b10;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (bus.slot_ack_o[0]) break;
      @(negedge clk);
    end
    req[0] = 1'b0;
    coin[1:0] = 2'b00;
    @(negedge clk);
    check("in_wait_busy", bus.busy_o, 1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_wait", {bus.slot_ack_o, bus.nickel_o, bus.dime_o, bus.quarter_o,
          bus.vend_valid_o, bus.reject_o, bus.credit_o, bus.busy_o, bus.err_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_coin(0, 2'b01, 3'd1);

    // machine withholds soda at credit 4: error sticks, credit saturates
    send_coin(0, 2'b01, 3'd2);
    send_coin(0, 2'b01, 3'd3);
    check("err_before", bus.err_o, 0);
    force_no_soda = 1'b1;
    send_coin(0, 2'b01, 3'd3);
    force_no_soda = 1'b0;
    check("err_set", bus.err_o, 1);
    send_coin(1, 2'b01, 3'd3);
    check("err_sticky", bus.err_o, 1);
`ifdef COIN_ARB_STATS_EN
    check("coin_cnt", bus.coin_cnt_o, 5);
    check("vend_cnt", bus.vend_cnt_o, 0);
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
